// File: rtl/reg_file.sv
// reg_file: architectural integer register file with two combinational read
// ports, same-cycle write bypass, hard-wired x0 and a post-reset clear sweep.
//
// state | meaning
// INIT  | sweep clears x1..x31 one per cycle; reads return 0, writes dropped
// RUN   | normal operation; writeback writes, decode reads with bypass
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_enable,
  input  logic                  halt,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  output logic                  ready,
  output logic                  wr_dropped
);

  typedef enum logic {INIT, RUN} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_idx, clr_idx_nxt;
  logic                  ready_nxt;
  logic                  dropped_nxt;
  logic                  we_eff;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  assign we_eff = (state == RUN) && wr_enable && !halt && (wr_addr != '0);

  // State, sweep index and status flags; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= INIT;
      clr_idx    <= ADDR_WIDTH'(1);
      ready      <= 1'b0;
      wr_dropped <= 1'b0;
    end else begin
      state      <= state_nxt;
      clr_idx    <= clr_idx_nxt;
      ready      <= ready_nxt;
      wr_dropped <= dropped_nxt;
    end
  end

  // Next-state logic: walk clr_idx to the last register, then enter RUN.
  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    ready_nxt   = ready;
    dropped_nxt = wr_dropped;
    case (state)
      INIT: begin
        if (wr_enable) dropped_nxt = 1'b1;
        if (clr_idx == ADDR_WIDTH'(NUM_REGS - 1)) begin
          state_nxt   = RUN;
          ready_nxt   = 1'b1;
          clr_idx_nxt = ADDR_WIDTH'(1);
        end else begin
          clr_idx_nxt = clr_idx + 1'b1;
        end
      end
      RUN: begin
        ready_nxt = 1'b1;
      end
      default: begin
        state_nxt = INIT;
      end
    endcase
  end

  // Array update: sweep clears during INIT, writeback writes during RUN.
  // Reset blocks both so a held reset leaves the contents untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state == INIT) begin
        regs[clr_idx] <= '0;
      end else if (we_eff) begin
        regs[wr_addr] <= wr_data;
      end
    end
  end

  // Read port 1: x0 and INIT force zero, then bypass, then array.
  always_comb begin
    rs1_data = '0;
    if (rs1_addr != '0 && state == RUN) begin
      if (we_eff && wr_addr == rs1_addr) rs1_data = wr_data;
      else                               rs1_data = regs[rs1_addr];
    end
  end

  // Read port 2: identical selection to port 1.
  always_comb begin
    rs2_data = '0;
    if (rs2_addr != '0 && state == RUN) begin
      if (we_eff && wr_addr == rs2_addr) rs2_data = wr_data;
      else                               rs2_data = regs[rs2_addr];
    end
  end

endmodule
